// File: rtl/lb_cmd_bridge.sv
// Byte-stream command bridge: opcode/address/data bytes in, local-bus strobes out, read data returned as bytes.
// Optional read-wait abort is enabled by defining LB_CMD_BRIDGE_TIMEOUT_EN.
module lb_cmd_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_lb,
    input  logic        reset,
    input  logic [7:0]  rx_byte_d,
    input  logic        rx_byte_en,
    output logic [7:0]  tx_byte_d,
    output logic        tx_byte_en,
    input  logic        tx_byte_rdy,
    output logic        lb_wr,
    output logic        lb_rd,
    output logic [31:0] lb_addr,
    output logic [31:0] lb_wr_d,
    input  logic [31:0] lb_rd_d,
    input  logic        lb_rd_rdy,
    output logic        busy,
    output logic        rx_overrun,
    output logic        rd_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        BUS_WR,
        BUS_RD,
        WAIT_RD,
        SEND_RSP
    } state_t;

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;

    state_t      state_q;
    logic        is_read_q;
    logic [1:0]  byte_cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wr_data_q;
    logic [31:0] rsp_q;
    logic [7:0]  tx_byte_q;
    logic        tx_en_q;
    logic        lb_wr_q;
    logic        lb_rd_q;

`ifdef LB_CMD_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] timer_q;
    logic        rd_timeout_q;
`endif

    always_ff @(posedge clk_lb) begin
        if (reset) begin
            state_q    <= IDLE;
            is_read_q  <= 1'b0;
            byte_cnt_q <= 2'd0;
            addr_q     <= 32'd0;
            wr_data_q  <= 32'd0;
            rsp_q      <= 32'd0;
            tx_byte_q  <= 8'd0;
            tx_en_q    <= 1'b0;
            lb_wr_q    <= 1'b0;
            lb_rd_q    <= 1'b0;
`ifdef LB_CMD_BRIDGE_TIMEOUT_EN
            timer_q      <= 16'd0;
            rd_timeout_q <= 1'b0;
`endif
        end else begin
            lb_wr_q <= 1'b0;
            lb_rd_q <= 1'b0;
`ifdef LB_CMD_BRIDGE_TIMEOUT_EN
            rd_timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (rx_byte_en && (rx_byte_d == OP_WRITE || rx_byte_d == OP_READ)) begin
                        is_read_q  <= (rx_byte_d == OP_READ);
                        byte_cnt_q <= 2'd0;
                        state_q    <= GET_ADDR;
                    end
                end
                GET_ADDR: begin
                    if (rx_byte_en) begin
                        addr_q     <= {addr_q[23:0], rx_byte_d};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            if (is_read_q) begin
                                lb_rd_q <= 1'b1;
                                state_q <= BUS_RD;
                            end else begin
                                state_q <= GET_DATA;
                            end
                        end
                    end
                end
                GET_DATA: begin
                    if (rx_byte_en) begin
                        wr_data_q  <= {wr_data_q[23:0], rx_byte_d};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            lb_wr_q <= 1'b1;
                            state_q <= BUS_WR;
                        end
                    end
                end
                BUS_WR: begin
                    state_q <= IDLE;
                end
                BUS_RD: begin
`ifdef LB_CMD_BRIDGE_TIMEOUT_EN
                    timer_q <= 16'd0;
`endif
                    state_q <= WAIT_RD;
                end
                WAIT_RD: begin
                    // Read data takes priority over a timeout landing on the same cycle.
                    if (lb_rd_rdy) begin
                        rsp_q      <= lb_rd_d;
                        tx_byte_q  <= lb_rd_d[31:24];
                        tx_en_q    <= 1'b1;
                        byte_cnt_q <= 2'd0;
                        state_q    <= SEND_RSP;
                    end
`ifdef LB_CMD_BRIDGE_TIMEOUT_EN
                    else if (timer_q == TIMER_LAST) begin
                        rd_timeout_q <= 1'b1;
                        rsp_q        <= 32'hFFFF_FFFF;
                        tx_byte_q    <= 8'hFF;
                        tx_en_q      <= 1'b1;
                        byte_cnt_q   <= 2'd0;
                        state_q      <= SEND_RSP;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
`endif
                end
                SEND_RSP: begin
                    if (tx_en_q && tx_byte_rdy) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            tx_en_q <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            tx_byte_q <= rsp_q[23:16];
                            rsp_q     <= {rsp_q[23:0], 8'h00};
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_byte_d  = tx_byte_q;
    assign tx_byte_en = tx_en_q;
    assign lb_wr      = lb_wr_q;
    assign lb_rd      = lb_rd_q;
    assign lb_addr    = addr_q;
    assign lb_wr_d    = wr_data_q;
    assign busy       = (state_q != IDLE);

    // Bytes arriving while the bridge cannot take them are dropped and flagged.
    assign rx_overrun = rx_byte_en && !reset &&
                        (state_q inside {BUS_WR, BUS_RD, WAIT_RD, SEND_RSP});

`ifdef LB_CMD_BRIDGE_TIMEOUT_EN
    assign rd_timeout = rd_timeout_q;
`else
    assign rd_timeout = 1'b0;
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_lb_cmd_bridge.sv
// Randomized bench for lb_cmd_bridge: command-level reference model with queues of expected bus and tx events.
module tb_lb_cmd_bridge;

    localparam int TO_CYC = 16;
`ifdef LB_CMD_BRIDGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk_lb = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_byte_d = 8'd0;
    logic        rx_byte_en = 1'b0;
    logic [7:0]  tx_byte_d;
    logic        tx_byte_en;
    logic        tx_byte_rdy = 1'b0;
    logic        lb_wr;
    logic        lb_rd;
    logic [31:0] lb_addr;
    logic [31:0] lb_wr_d;
    logic [31:0] lb_rd_d = 32'd0;
    logic        lb_rd_rdy = 1'b0;
    logic        busy;
    logic        rx_overrun;
    logic        rd_timeout;

    lb_cmd_bridge #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk_lb      (clk_lb),
        .reset       (reset),
        .rx_byte_d   (rx_byte_d),
        .rx_byte_en  (rx_byte_en),
        .tx_byte_d   (tx_byte_d),
        .tx_byte_en  (tx_byte_en),
        .tx_byte_rdy (tx_byte_rdy),
        .lb_wr       (lb_wr),
        .lb_rd       (lb_rd),
        .lb_addr     (lb_addr),
        .lb_wr_d     (lb_wr_d),
        .lb_rd_d     (lb_rd_d),
        .lb_rd_rdy   (lb_rd_rdy),
        .busy        (busy),
        .rx_overrun  (rx_overrun),
        .rd_timeout  (rd_timeout)
    );

    always #5 clk_lb = ~clk_lb;

    int cyc = 0;
    always @(posedge clk_lb) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          at;
    } wr_t;
    typedef struct {
        logic [31:0] addr;
        int          at;
    } rd_t;

    wr_t        exp_wr[$];
    rd_t        exp_rd[$];
    logic [7:0] exp_tx[$];
    wr_t        w_pop;
    rd_t        r_pop;

    int   checks = 0;
    int   failures = 0;
    int   ovr_seen = 0;
    int   ovr_exp = 0;
    int   to_seen = 0;
    int   to_exp = 0;
    int   exp_to_cyc = -1;
    int   k_last = 0;
    int   rdy_mode = 0;
    bit   mon_en = 1'b0;
    bit   hold_q = 1'b0;
    logic [7:0] held_byte = 8'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Downstream ready pattern: always, random, or one cycle in three.
    initial forever begin
        @(posedge clk_lb);
        #1;
        case (rdy_mode)
            0:       tx_byte_rdy = 1'b1;
            1:       tx_byte_rdy = 1'($urandom % 2);
            default: tx_byte_rdy = (cyc % 3 == 0);
        endcase
    end

    always @(negedge clk_lb) begin
        if (mon_en) begin
            check("wr_rd_excl", 32'(lb_wr & lb_rd), 32'd0);
            if (lb_wr) begin
                if (exp_wr.size() == 0) check("wr_unexpected", 32'(lb_wr), 32'd0);
                else begin
                    w_pop = exp_wr.pop_front();
                    check("wr_addr", lb_addr, w_pop.addr);
                    check("wr_data", lb_wr_d, w_pop.data);
                    check("wr_cycle", 32'(cyc), 32'(w_pop.at));
                end
            end
            if (lb_rd) begin
                if (exp_rd.size() == 0) check("rd_unexpected", 32'(lb_rd), 32'd0);
                else begin
                    r_pop = exp_rd.pop_front();
                    check("rd_addr", lb_addr, r_pop.addr);
                    check("rd_cycle", 32'(cyc), 32'(r_pop.at));
                end
            end
            if (rx_overrun) ovr_seen++;
            if (rd_timeout) begin
                to_seen++;
                check("rd_timeout_cycle", 32'(cyc), 32'(exp_to_cyc));
            end
            if (hold_q) begin
                check("tx_held_en", 32'(tx_byte_en), 32'd1);
                check("tx_held_byte", 32'(tx_byte_d), 32'(held_byte));
            end
            if (tx_byte_en) begin
                if (exp_tx.size() == 0) check("tx_unexpected", 32'(tx_byte_en), 32'd0);
                else if (tx_byte_rdy) check("tx_byte", 32'(tx_byte_d), 32'(exp_tx.pop_front()));
            end
            hold_q    = tx_byte_en && !tx_byte_rdy;
            held_byte = tx_byte_d;
        end
    end

    task automatic tick();
        @(posedge clk_lb);
        #1;
    endtask

    task automatic tick_clr();
        tick();
        rx_byte_en = 1'b0;
        lb_rd_rdy  = 1'b0;
    endtask

    function automatic int rgap(input bit rnd);
        int r;
        if (!rnd) return 0;
        r = int'($urandom % 8);
        return (r == 0) ? 12 : r % 3;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        rx_byte_d  = b;
        rx_byte_en = 1'b1;
        k_last     = cyc;
        tick();
        rx_byte_en = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input bit rnd);
        send_byte(8'h01, rgap(rnd));
        for (int i = 0; i < 4; i++) send_byte(addr[31-8*i -: 8], rgap(rnd));
        for (int i = 0; i < 4; i++) send_byte(data[31-8*i -: 8], rgap(rnd));
        exp_wr.push_back('{addr: addr, data: data, at: k_last + 1});
        tick();
        check("wr_idle", 32'(busy), 32'd0);
        $display("WR addr=%08h data=%08h", addr, data);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input int extra,
                           input bit respond, input bit junk, input bit inject, input bit rnd);
        int   entry;
        bit   timed_out;
        logic [31:0] rsp;
        send_byte(8'h02, rgap(rnd));
        for (int i = 0; i < 4; i++) send_byte(addr[31-8*i -: 8], rgap(rnd));
        exp_rd.push_back('{addr: addr, at: k_last + 1});
        entry = k_last + 2;
        if (junk) begin
            lb_rd_rdy = 1'b1;
            lb_rd_d   = ~data;
        end
        tick_clr();
        if (inject) begin
            rx_byte_d  = 8'($urandom);
            rx_byte_en = 1'b1;
            ovr_exp++;
        end
        timed_out = TO_EN && (!respond || extra >= TO_CYC);
        rsp = timed_out ? 32'hFFFF_FFFF : data;
        if (timed_out) begin
            exp_to_cyc = entry + TO_CYC;
            to_exp++;
        end
        if (!respond && !timed_out) begin
            repeat (40) tick_clr();
            check("stuck_busy", 32'(busy), 32'd1);
            $display("RD addr=%08h no response, bridge waiting", addr);
        end else begin
            for (int i = 0; i < 4; i++) exp_tx.push_back(rsp[31-8*i -: 8]);
            if (respond) begin
                repeat (extra) tick_clr();
                lb_rd_rdy = 1'b1;
                lb_rd_d   = data;
            end
            tick_clr();
            for (int i = 0; i < 400 && (busy || exp_tx.size() != 0); i++) tick_clr();
            check("rsp_done_busy", 32'(busy), 32'd0);
            check("rsp_bytes_left", 32'(exp_tx.size()), 32'd0);
            $display("RD addr=%08h rsp=%08h timeout=%0d", addr, rsp, timed_out);
        end
        check("timeout_count", 32'(to_seen), 32'(to_exp));
        check("overrun_count", 32'(ovr_seen), 32'(ovr_exp));
        exp_to_cyc = -1;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        hold_q = 1'b0;
        reset  = 1'b1;
        exp_tx.delete();
        tick_clr();
        tick_clr();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_en", 32'(tx_byte_en), 32'd0);
        check("rst_addr", lb_addr, 32'd0);
        check("rst_wr_d", lb_wr_d, 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();
        check("post_rst_wr", 32'(lb_wr), 32'd0);
        check("post_rst_rd", 32'(lb_rd), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        $display("RESET applied");
    endtask

    initial begin
        logic [7:0] bad_ops [6];
        bad_ops = '{8'h7F, 8'h00, 8'h03, 8'hFF, 8'h81, 8'h10};

        rx_byte_en = 1'b1;
        rx_byte_d  = 8'h01;
        repeat (3) tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_lb_wr", 32'(lb_wr), 32'd0);
        check("reset_lb_rd", 32'(lb_rd), 32'd0);
        check("reset_lb_addr", lb_addr, 32'd0);
        check("reset_lb_wr_d", lb_wr_d, 32'd0);
        check("reset_tx_d", 32'(tx_byte_d), 32'd0);
        check("reset_tx_en", 32'(tx_byte_en), 32'd0);
        check("reset_overrun", 32'(rx_overrun), 32'd0);
        check("reset_timeout", 32'(rd_timeout), 32'd0);
        rx_byte_en = 1'b0;
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();

        // Directed: basic write, read, backpressured read, overrun, bad opcodes.
        do_write(32'h0000_0004, 32'hCAFE_BABE, 1'b0);
        rdy_mode = 0;
        do_read(32'h0000_0000, 32'h1234_5678, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        rdy_mode = 2;
        do_read(32'h0000_0000, 32'h1234_5678, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        rdy_mode = 0;
        do_read(32'hA5A5_0010, 32'h8765_4321, 2, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            lb_rd_rdy = 1'b1;
            lb_rd_d   = 32'($urandom);
            send_byte(bad_ops[i], 1);
            lb_rd_rdy = 1'b0;
            check("badop_busy", 32'(busy), 32'd0);
            $display("BADOP %02h", bad_ops[i]);
        end

        // Read with no responder: aborts with FF bytes if enabled, otherwise stays busy.
        do_read(32'h0000_0100, 32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (busy) do_reset();
        do_read(32'h0000_0200, 32'hDEAD_0015, TO_CYC - 1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a command, then a clean write.
        send_byte(8'h01, 0);
        for (int i = 0; i < 3; i++) send_byte(8'h11 * (i + 1), 0);
        do_reset();
        do_write(32'h0000_0004, 32'hCAFE_BABE, 1'b0);

        for (int n = 0; n < 30; n++) begin
            rdy_mode = int'($urandom % 3);
            if ($urandom % 2 == 0)
                do_write(32'($urandom), 32'($urandom), 1'b1);
            else
                do_read(32'($urandom), 32'($urandom), int'($urandom % 6), 1'b1,
                        1'($urandom % 2), 1'($urandom % 2), 1'b1);
        end

        repeat (4) tick();
        check("wr_pending", 32'(exp_wr.size()), 32'd0);
        check("rd_pending", 32'(exp_rd.size()), 32'd0);
        check("overrun_total", 32'(ovr_seen), 32'(ovr_exp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lb_cmd_bridge.md
LB_CMD_BRIDGE -- requirements
Module: lb_cmd_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning read-wait cycles before abort (1..65535).
REQ-002 SHALL have port clk_lb  input  1  the single clock for all logic.
REQ-003 SHALL have port reset  input  1  reset, synchronous to clk_lb and active-high.
REQ-004 SHALL have port rx_byte_d  input  8  command byte from upstream byte source.
REQ-005 SHALL have port rx_byte_en  input  1  rx_byte_d valid for exactly this cycle; no backpressure.
REQ-006 SHALL have port tx_byte_d  output  8  response byte.
REQ-007 SHALL have port tx_byte_en  output  1  tx_byte_d valid; held until accepted.
REQ-008 SHALL have port tx_byte_rdy  input  1  downstream accepts when tx_byte_en && tx_byte_rdy.
REQ-009 SHALL have ports lb_wr, lb_rd  output  1 each  single-cycle local bus strobes.
REQ-010 SHALL have ports lb_addr, lb_wr_d  output  32 each  local bus address and write data.
REQ-011 SHALL have ports lb_rd_d  input  32, lb_rd_rdy  input  1  read data and one-cycle data-valid strobe.
REQ-012 SHALL have ports busy  output  1 (state != IDLE), rx_overrun  output  1 (one-cycle pulse), rd_timeout  output  1 (one-cycle pulse).

Function
REQ-013 SHALL implement states IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, WAIT_RD, SEND_RSP.
REQ-014 SHALL, in IDLE, accept opcode byte: 0x01 = write, 0x02 = read -> GET_ADDR; any other value ignored, stay IDLE.
REQ-015 SHALL collect 4 address bytes in GET_ADDR, MSB first, into lb_addr; then write -> GET_DATA, read -> BUS_RD.
REQ-016 SHALL collect 4 data bytes in GET_DATA, MSB first, into lb_wr_d; then -> BUS_WR.
REQ-017 SHALL assert lb_wr for exactly one cycle, the cycle after the last data byte, then return to IDLE.
REQ-018 SHALL assert lb_rd for exactly one cycle, the cycle after the last address byte, then enter WAIT_RD.
REQ-019 SHALL hold lb_addr and lb_wr_d stable from strobe until the next command's first address/data byte overwrites them.
REQ-020 SHALL, in WAIT_RD, capture lb_rd_d on the first lb_rd_rdy and enter SEND_RSP; lb_rd_rdy outside WAIT_RD is ignored.
REQ-021 SHALL, in SEND_RSP, present 4 captured bytes MSB first on tx_byte_d with tx_byte_en high, advancing only on tx_byte_en && tx_byte_rdy; after the 4th transfer -> IDLE.
REQ-022 SHALL drop any rx_byte_en occurring in BUS_WR, BUS_RD, WAIT_RD or SEND_RSP and pulse rx_overrun that cycle.
REQ-023 SHALL keep tx_byte_en low outside SEND_RSP; lb_wr and lb_rd never asserted together.
REQ-024 SHALL impose no timeout between received command bytes.

Reset
REQ-025 SHALL, on reset, force state IDLE, byte counters 0, lb_wr=0, lb_rd=0, lb_addr=0, lb_wr_d=0, tx_byte_d=0, tx_byte_en=0, busy=0, rx_overrun=0, rd_timeout=0, timeout counter 0.
REQ-026 SHALL abort any in-progress command on reset mid-operation, discarding partial bytes and pending response; no strobe issued the cycle after reset deasserts.

Configuration
REQ-027 SHALL, with macro LB_CMD_BRIDGE_TIMEOUT_EN defined, count cycles in WAIT_RD; when count reaches TIMEOUT_CYCLES without lb_rd_rdy, pulse rd_timeout, load response 0xFFFFFFFF and enter SEND_RSP.
REQ-028 SHALL, with LB_CMD_BRIDGE_TIMEOUT_EN undefined, omit the counter, wait in WAIT_RD indefinitely, and tie rd_timeout to 0.
REQ-029 SHALL treat lb_rd_rdy arriving on the same cycle the count reaches TIMEOUT_CYCLES as a valid read (data wins, no rd_timeout).

Verification
REQ-030 SHALL cover write: bytes 01 00 00 00 04 CA FE BA BE -> one-cycle lb_wr with lb_addr=0x00000004, lb_wr_d=0xCAFEBABE, next cycle after last byte.
REQ-031 SHALL cover read: 02 00 00 00 00, lb_rd_rdy one cycle after lb_rd with lb_rd_d=0x12345678, tx_byte_rdy=1 -> tx bytes 12 34 56 78.
REQ-032 SHALL cover backpressure: read response with tx_byte_rdy toggling 1-of-3 cycles -> bytes held stable, order 12 34 56 78, no loss/duplication.
REQ-033 SHALL cover overrun and bad opcode: byte during WAIT_RD -> rx_overrun pulse, byte dropped; opcode 0x7F -> no strobes, busy stays 0.
REQ-034 SHALL cover timeout (macro defined, TIMEOUT_CYCLES=16): no lb_rd_rdy -> rd_timeout pulse 16 cycles after WAIT_RD entry, tx bytes FF FF FF FF; macro undefined -> busy remains 1.
REQ-035 SHALL cover reset after 3 address bytes -> IDLE, then a full write command completes correctly.
